// File: rtl/midi_rx.sv
// rtl/midi_rx.sv - 8N1 MIDI IN receiver with a pop-on-read byte FIFO and sticky error flags.
module midi_rx #(
    parameter int CLKDIV = 896,
    parameter int DEPTH  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] q,
    output logic       ready,
    output logic       ferr,
    output logic       ovf,
    input  logic       clr
);
    localparam int TW = $clog2(CLKDIV);
    localparam int AW = $clog2(DEPTH);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKDIV / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKDIV - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rxs_q;
    logic [1:0]    flush_q, flush_d;
    logic          rx_hi_q, rx_hi_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
    logic          ferr_q, ferr_d, ovf_q, ovf_d;
    logic [7:0]    mem [DEPTH];

    logic expired, fall, push, ferr_set;
    logic empty, full, pop_ok, push_ok;

    // The synchroniser powers up high, so a fall only counts once a genuine high has been sampled.
    assign expired = (timer_q == '0);
    assign fall    = flush_q[1] && rx_hi_q && !rxs_q;

    always_comb begin
        state_d  = state_q;
        timer_d  = expired ? timer_q : timer_q - TIMER_ONE;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        flush_d  = {flush_q[0], 1'b1};
        rx_hi_d  = flush_q[1] ? rxs_q : 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    timer_d = HALF_LOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (expired) begin
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        timer_d = FULL_LOAD;
                        bit_d   = 3'd0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (expired) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    timer_d = FULL_LOAD;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            S_STOP: begin
                if (expired) begin
                    if (rxs_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A pop frees the head slot in the same edge, so a push into a full FIFO may reuse it.
    assign empty   = (wp_q == rp_q);
    assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign pop_ok  = rd && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wp_d   = wp_q + {{AW{1'b0}}, push_ok};
        rp_d   = rp_q + {{AW{1'b0}}, pop_ok};
        ferr_d = (ferr_q && !clr) || ferr_set;
        ovf_d  = (ovf_q && !clr) || (push && !push_ok);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            flush_q   <= 2'b00;
            rx_hi_q   <= 1'b0;
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            wp_q      <= '0;
            rp_q      <= '0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
            flush_q   <= flush_d;
            rx_hi_q   <= rx_hi_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push_ok) mem[wp_q[AW-1:0]] <= shift_q;
    end

    assign ready = !empty;
    assign q     = ready ? mem[rp_q[AW-1:0]] : 8'h00;
    assign ferr  = ferr_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_midi_rx.sv
// tb/tb_midi_rx.sv - randomized and directed bench for midi_rx against a frame-level queue model.
module tb_midi_rx;
    localparam int CLKDIV   = 8;
    localparam int DEPTH    = 4;
    localparam int PUSH_LAT = 78;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       rd    = 1'b0;
    logic       clr   = 1'b0;
    logic [7:0] q;
    logic       ready, ferr, ovf;

    always #5 clock = ~clock;

    midi_rx #(.CLKDIV(CLKDIV), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .rx(rx), .rd(rd),
        .q(q), .ready(ready), .ferr(ferr), .ovf(ovf), .clr(clr)
    );

    int checks   = 0;
    int failures = 0;

    // Transmit job table: written by the main sequence, consumed by the line driver.
    logic [7:0] tx_data   [256];
    bit         tx_bad    [256];
    int         tx_gap    [256];
    int         tx_hold   [256];
    int         tx_glitch [256];
    int         tx_tail = 0;
    int         tx_head = 0;
    int         frames_started = 0;
    int         last_n = 0;

    typedef struct {
        int         cyc;
        int         epoch;
        bit         is_ferr;
        logic [7:0] data;
    } ev_t;
    ev_t evq[$];

    int         cyc   = 0;
    int         epoch = 0;
    logic [7:0] mfifo[$];
    bit         m_ferr = 1'b0, m_ovf = 1'b0;
    bit         m_push, m_fe, m_ovf_set;
    logic [7:0] m_pd;

    // Reference: a frame whose start bit first reaches the pin before edge N lands at edge N+78.
    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            mfifo.delete();
            m_ferr = 1'b0;
            m_ovf  = 1'b0;
            epoch++;
        end else begin
            m_push = 1'b0; m_fe = 1'b0; m_pd = 8'h00; m_ovf_set = 1'b0;
            foreach (evq[i]) begin
                if (evq[i].cyc == cyc && evq[i].epoch == epoch) begin
                    if (evq[i].is_ferr) m_fe = 1'b1;
                    else begin m_push = 1'b1; m_pd = evq[i].data; end
                end
            end
            if (rd && mfifo.size() > 0) void'(mfifo.pop_front());
            if (m_push) begin
                if (mfifo.size() < DEPTH) mfifo.push_back(m_pd);
                else m_ovf_set = 1'b1;
            end
            m_ferr = (m_ferr && !clr) || m_fe;
            m_ovf  = (m_ovf && !clr) || m_ovf_set;
        end
    end

    initial begin
        int idx, n;
        @(negedge clock);
        forever begin
            if (tx_head < tx_tail) begin
                idx = tx_head;
                repeat (tx_gap[idx]) @(negedge clock);
                if (tx_glitch[idx] > 0) begin
                    rx = 1'b0;
                    repeat (tx_glitch[idx]) @(negedge clock);
                    rx = 1'b1;
                    repeat (6) @(negedge clock);
                end else begin
                    rx = 1'b0;
                    n = cyc + 1;
                    last_n = n;
                    evq.push_back('{cyc: n + PUSH_LAT, epoch: epoch, is_ferr: tx_bad[idx], data: tx_data[idx]});
                    frames_started++;
                    repeat (CLKDIV) @(negedge clock);
                    for (int b = 0; b < 8; b++) begin
                        rx = tx_data[idx][b];
                        repeat (CLKDIV) @(negedge clock);
                    end
                    rx = !tx_bad[idx];
                    repeat (CLKDIV) @(negedge clock);
                    if (tx_bad[idx]) begin
                        rx = 1'b0;
                        repeat (tx_hold[idx]) @(negedge clock);
                        rx = 1'b1;
                        repeat (2) @(negedge clock);
                    end
                    rx = 1'b1;
                end
                tx_head++;
            end else begin
                @(negedge clock);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp_v);
        end
    endtask

    task automatic queue_frame(input logic [7:0] d, input bit bad, input int gap, input int hold, input int glitch);
        tx_data[tx_tail]   = d;
        tx_bad[tx_tail]    = bad;
        tx_gap[tx_tail]    = gap;
        tx_hold[tx_tail]   = hold;
        tx_glitch[tx_tail] = glitch;
        tx_tail++;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (tx_head < tx_tail && k < budget) begin @(negedge clock); k++; end
        chk("tx_idle_timeout", tx_tail - tx_head, 0);
    endtask

    task automatic wait_frames(input int target);
        int k = 0;
        while (frames_started < target && k < 2000) begin @(negedge clock); k++; end
        chk("frame_start_timeout", frames_started, target);
    endtask

    task automatic wait_cycle(input int target);
        int k = 0;
        while (cyc < target && k < 2000) begin @(negedge clock); k++; end
        chk("cycle_wait", cyc, target);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] d);
        chk(name, q, d);
        rd = 1'b1;
        @(negedge clock);
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clock);
        clr = 1'b0;
    endtask

    initial begin
        int base, n;
        fork
            forever begin
                @(posedge clock);
                #1;
                chk("ready", ready, mfifo.size() > 0);
                chk("q", q, (mfifo.size() > 0) ? mfifo[0] : 8'h00);
                chk("ferr", ferr, m_ferr);
                chk("ovf", ovf, m_ovf);
            end
        join_none

        repeat (3) @(negedge clock);
        chk("rst_ready", ready, 0);
        chk("rst_q", q, 8'h00);
        chk("rst_ferr", ferr, 0);
        chk("rst_ovf", ovf, 0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Single byte: exact ready latency.
        base = frames_started;
        queue_frame(8'h90, 0, 0, 0, 0);
        wait_frames(base + 1);
        n = last_n;
        wait_cycle(n + PUSH_LAT - 1);
        chk("single_ready_early", ready, 0);
        @(negedge clock);
        chk("single_ready", ready, 1);
        pop_expect("single_q", 8'h90);
        chk("single_empty", ready, 0);
        chk("single_q_zero", q, 8'h00);
        wait_idle(200);

        // Burst overflow.
        queue_frame(8'h90, 0, 0, 0, 0);
        queue_frame(8'h3C, 0, 0, 0, 0);
        queue_frame(8'h7F, 0, 0, 0, 0);
        queue_frame(8'h80, 0, 0, 0, 0);
        queue_frame(8'h45, 0, 0, 0, 0);
        wait_idle(800);
        repeat (10) @(negedge clock);
        chk("burst_ovf", ovf, 1);
        pop_expect("burst_q0", 8'h90);
        pop_expect("burst_q1", 8'h3C);
        pop_expect("burst_q2", 8'h7F);
        pop_expect("burst_q3", 8'h80);
        chk("burst_empty", ready, 0);
        pulse_clr();
        chk("burst_clr", ovf, 0);

        // Framing error with a long break, then a good byte.
        queue_frame(8'hAA, 1, 0, 30 * CLKDIV, 0);
        queue_frame(8'h55, 0, 0, 0, 0);
        wait_idle(1000);
        repeat (10) @(negedge clock);
        chk("ferr_set", ferr, 1);
        pop_expect("ferr_next_byte", 8'h55);
        chk("ferr_no_extra", ready, 0);
        pulse_clr();
        chk("ferr_clr", ferr, 0);

        // False start.
        queue_frame(8'h00, 0, 0, 0, 3);
        wait_idle(100);
        repeat (10) @(negedge clock);
        chk("glitch_ready", ready, 0);
        chk("glitch_ferr", ferr, 0);

        // Full FIFO with a pop landing on the 5th stop sample.
        base = frames_started;
        queue_frame(8'h11, 0, 0, 0, 0);
        queue_frame(8'h22, 0, 0, 0, 0);
        queue_frame(8'h33, 0, 0, 0, 0);
        queue_frame(8'h44, 0, 0, 0, 0);
        queue_frame(8'h5A, 0, 0, 0, 0);
        wait_frames(base + 5);
        n = last_n;
        wait_cycle(n + PUSH_LAT - 1);
        rd = 1'b1;
        @(negedge clock);
        rd = 1'b0;
        chk("fullpop_ovf", ovf, 0);
        wait_idle(200);
        pop_expect("fullpop_q0", 8'h22);
        pop_expect("fullpop_q1", 8'h33);
        pop_expect("fullpop_q2", 8'h44);
        pop_expect("fullpop_q3", 8'h5A);
        chk("fullpop_empty", ready, 0);

        // Reset mid-frame.
        queue_frame(8'hA5, 0, 0, 0, 0);
        wait_idle(200);
        repeat (5) @(negedge clock);
        chk("pre_reset_ready", ready, 1);
        base = frames_started;
        queue_frame(8'hF8, 0, 0, 0, 0);
        wait_frames(base + 1);
        wait_cycle(last_n + 42);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_ready", ready, 0);
        chk("midrst_q", q, 8'h00);
        wait_idle(200);
        repeat (5) @(negedge clock);
        queue_frame(8'hFE, 0, 0, 0, 0);
        wait_idle(200);
        repeat (5) @(negedge clock);
        pop_expect("midrst_fe", 8'hFE);
        chk("midrst_alone", ready, 0);

        // Random traffic: slow readers first, then fast readers.
        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < 25; i++) begin
                if ($urandom_range(0, 9) == 0)
                    queue_frame(8'h00, 0, $urandom_range(0, 20), 0, $urandom_range(1, 3));
                else if ($urandom_range(0, 7) == 0)
                    queue_frame(8'($urandom), 1, $urandom_range(0, 20), $urandom_range(0, 40), 0);
                else
                    queue_frame(8'($urandom), 0, $urandom_range(0, 20), 0, 0);
            end
            begin
                int k = 0;
                while (tx_head < tx_tail && k < 20000) begin
                    rd  = ($urandom_range(0, (phase == 0) ? 150 : 3) == 0);
                    clr = ($urandom_range(0, 40) == 0);
                    @(negedge clock);
                    k++;
                end
                rd = 1'b0;
                clr = 1'b0;
                chk("rand_timeout", tx_tail - tx_head, 0);
            end
            repeat (20) @(negedge clock);
            for (int i = 0; i < DEPTH + 1; i++) begin
                rd = 1'b1;
                @(negedge clock);
            end
            rd = 1'b0;
            @(negedge clock);
        end

        repeat (4) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
